mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 30 +++
 rtl/mult_div_unit_div_step.sv | 25 ++
 rtl/mult_div_unit.sv | 193 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, iteration count.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package mult_div_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    localparam int ITER = 32;

    localparam op_t OP_MULT  = 2'b00;
    localparam op_t OP_MULTU = 2'b01;
    localparam op_t OP_DIV   = 2'b10;
    localparam op_t OP_DIVU  = 2'b11;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_FIX  = 2'd2;

    // Two's-complement negate of a 32-bit value
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // MULT and DIV are the signed flavours (op[0] clear)
    function automatic logic op_is_signed(input op_t o);
        return ~o[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: n/a.
module div_step (
    input  logic [31:0] rem_in,
    input  logic        dividend_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_bit
);

    logic [32:0] partial;
    logic [32:0] diff;

    // Trial subtract; a non-negative difference means the quotient bit is 1.
    // Because rem_in < divisor (or divisor is zero), partial < 2*divisor and the
    // kept remainder always fits back into 32 bits.
    always_comb begin
        partial = {rem_in, dividend_bit};
        diff    = partial - {1'b0, divisor};
        q_bit   = ~diff[32];
        rem_out = q_bit ? diff[31:0] : partial[31:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers; divide enabled by macro MULT_DIV_UNIT_DIV_EN.
// Latency: start accepted at edge 0, 32 CALC edges, HI/LO written at edge 33, done pulses the next cycle.
// Backpressure: start is only honoured in IDLE; start or MTHI/MTLO while busy are dropped.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;      // product high half / partial remainder
    logic [31:0] mq_q, mq_d;        // multiplier shifting out / dividend->quotient
    logic [31:0] b_q, b_d;          // multiplicand or divisor magnitude
    logic        neg_res_q, neg_res_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        start_ok;
    logic        sgn;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [32:0] mul_sum;
    logic [63:0] prod;
    logic [63:0] prod_fix;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic        is_div_q, is_div_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic [31:0] rem_nxt;
    logic        q_bit;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    div_step u_div_step (
        .rem_in       (acc_q),
        .dividend_bit (mq_q[31]),
        .divisor      (b_q),
        .rem_out      (rem_nxt),
        .q_bit        (q_bit)
    );
`endif

    // Operand magnitudes at start, one shift-add step, and final sign correction
    always_comb begin
`ifdef MULT_DIV_UNIT_DIV_EN
        start_ok = start;
`else
        start_ok = start & ~op[1];
`endif
        sgn      = op_is_signed(op);
        rs_mag   = (sgn && rs_data[31]) ? neg32(rs_data) : rs_data;
        rt_mag   = (sgn && rt_data[31]) ? neg32(rt_data) : rt_data;
        mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : 33'd0);
        prod     = {acc_q, mq_q};
        prod_fix = neg_res_q ? (~prod + 64'd1) : prod;
`ifdef MULT_DIV_UNIT_DIV_EN
        // Divide by zero leaves the natural all-ones quotient; force it so the
        // signed sign-fix cannot turn it into 1.
        quo_fix  = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? neg32(mq_q) : mq_q);
        rem_fix  = neg_rem_q ? neg32(acc_q) : acc_q;
`endif
    end

    // Next-state: IDLE accepts start or MTHI/MTLO, CALC iterates, FIX writes HI/LO
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d   = ST_CALC;
                    cnt_d     = 5'd0;
                    acc_d     = 32'd0;
                    mq_d      = rs_mag;
                    b_d       = rt_mag;
                    neg_res_d = sgn & (rs_data[31] ^ rt_data[31]);
`ifdef MULT_DIV_UNIT_DIV_EN
                    is_div_d  = op[1];
                    neg_rem_d = sgn & rs_data[31];
                    div0_d    = (rt_data == 32'd0);
`endif
                end else if (!start) begin
                    // Any start in the same cycle takes priority over MTHI/MTLO
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_CALC: begin
`ifdef MULT_DIV_UNIT_DIV_EN
                if (is_div_q) begin
                    acc_d = rem_nxt;
                    mq_d  = {mq_q[30:0], q_bit};
                end else begin
                    acc_d = mul_sum[32:1];
                    mq_d  = {mul_sum[0], mq_q[31:1]};
                end
`else
                acc_d = mul_sum[32:1];
                mq_d  = {mul_sum[0], mq_q[31:1]};
`endif
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
`ifdef MULT_DIV_UNIT_DIV_EN
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
`else
                hi_d = prod_fix[63:32];
                lo_d = prod_fix[31:0];
`endif
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 32'd0;
            mq_q      <= 32'd0;
            b_q       <= 32'd0;
            neg_res_q <= 1'b0;
            hi_q      <= HILO_RST;
            lo_q      <= HILO_RST;
            done_q    <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MULT_DIV_UNIT_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (both divide-enabled and multiply-only builds).
// Latency: checks done/busy timing against the 33-edge schedule.
// Backpressure: exercises start/MTHI while busy and start+MTHI collisions.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam logic [31:0] RST_VAL = 32'h1357_9BDF;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_bad   = 0;

    mult_div_unit #(.HILO_RST(RST_VAL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Full operation with timing checks; optionally fires MTHI alongside start
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic we_too,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi_before;
        @(negedge clk);
        hi_before = hi;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        hi_we = we_too; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        check_val({tag, "_busy_e0"}, 64'(busy), 64'd1);
        check_val({tag, "_hi_e0"}, 64'(hi), 64'(hi_before));
        repeat (ITER) @(posedge clk);
        #1;
        check_val({tag, "_done_e32"}, 64'(done), 64'd0);
        check_val({tag, "_busy_e32"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        check_val({tag, "_done_e33"}, 64'(done), 64'd1);
        check_val({tag, "_busy_e33"}, 64'(busy), 64'd0);
        check_val({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check_val({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clk); #1;
        check_val({tag, "_done_e34"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n_done;
        int n_busy;
        logic [31:0] hi_keep;
        logic [31:0] lo_keep;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #23;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_hi", 64'(hi), 64'(RST_VAL));
        check_val("rst_lo", 64'(lo), 64'(RST_VAL));
        @(negedge clk);
        rst_n = 1'b1;

        // MTHI / MTLO in IDLE
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check_val("mthi", 64'(hi), 64'h1234);
        check_val("mtlo", 64'(lo), 64'h1234);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_m2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_2x3", OP_MULTU, 32'd2, 32'd3, 1'b1, 32'h0, 32'd6);
        run_op("mult_min2", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0);
        run_op("mult_m1m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'd1);

`ifdef MULT_DIV_UNIT_DIV_EN
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7_0", OP_DIVU, 32'd7, 32'd0, 1'b0, 32'd7, 32'hFFFF_FFFF);
        run_op("div_m7_0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFD);
`else
        // Divide request in a multiply-only build must be a no-op
        hi_keep = hi; lo_keep = lo;
        @(negedge clk);
        start = 1'b1; op = OP_DIV; rs_data = 32'd100; rt_data = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("nodiv_busy_e0", 64'(busy), 64'd0);
        n_done = 0; n_busy = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        check_val("nodiv_done_cnt", 64'(n_done), 64'd0);
        check_val("nodiv_busy_cnt", 64'(n_busy), 64'd0);
        check_val("nodiv_hi", 64'(hi), 64'(hi_keep));
        check_val("nodiv_lo", 64'(lo), 64'(lo_keep));
        run_op("nodiv_mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
`endif

        // Second start and MTHI while busy are both ignored
        hi_keep = hi;
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; rs_data = 32'd3; rt_data = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = OP_MULTU; rs_data = 32'd9; rt_data = 32'd9;
        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        check_val("busy_hi_held", 64'(hi), 64'(hi_keep));
        repeat (27) @(posedge clk);
        #1;
        check_val("busy_done_e32", 64'(done), 64'd0);
        @(posedge clk); #1;
        check_val("busy_done_e33", 64'(done), 64'd1);
        check_val("busy_hi", 64'(hi), 64'h0);
        check_val("busy_lo", 64'(lo), 64'd12);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; rs_data = 32'd100; rt_data = 32'd7;
`ifdef MULT_DIV_UNIT_DIV_EN
        op = OP_DIVU;
`else
        op = OP_MULTU;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", 64'(busy), 64'd0);
        check_val("arst_done", 64'(done), 64'd0);
        check_val("arst_hi", 64'(hi), 64'(RST_VAL));
        check_val("arst_lo", 64'(lo), 64'(RST_VAL));
        #1;
        rst_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check_val("arst_no_done", 64'(n_done), 64'd0);
        run_op("post_rst_5x5", OP_MULTU, 32'd5, 32'd5, 1'b0, 32'h0, 32'd25);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
